// File: rtl/draw_pkg.sv
// Shared types and constants for the rectangle draw engine.
package draw_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

endpackage

// File: rtl/rect_draw_engine_if.sv
// Request and pixel-stream handshake bundle of rect_draw_engine.
// slave = engine view, master = requester/sink view.
interface rect_draw_if #(
  parameter int X_W      = 9,
  parameter int Y_W      = 9,
  parameter int COLOUR_W = 6,
  parameter int SIZE_W   = 9
);
  logic                req_valid;
  logic                req_ready;
  logic [X_W-1:0]      req_x;
  logic [Y_W-1:0]      req_y;
  logic [SIZE_W-1:0]   req_w;
  logic [SIZE_W-1:0]   req_h;
  logic [COLOUR_W-1:0] req_colour;
  logic                req_mode;
  logic                pix_valid;
  logic                pix_ready;
  logic [X_W-1:0]      pix_x;
  logic [Y_W-1:0]      pix_y;
  logic [COLOUR_W-1:0] pix_colour;

  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h, req_colour, req_mode, pix_ready,
    output req_ready, pix_valid, pix_x, pix_y, pix_colour
  );

  modport master (
    output req_valid, req_x, req_y, req_w, req_h, req_colour, req_mode, pix_ready,
    input  req_ready, pix_valid, pix_x, pix_y, pix_colour
  );
endinterface

// File: rtl/rect_draw_engine_scan.sv
// 2-D col/row scan counter. Exposes the position the scan moves to next, so
// the engine can register that pixel's output ahead of time.
module rect_scan_counter #(
  parameter int SIZE_W = 9
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [SIZE_W-1:0] w_i,
  input  logic [SIZE_W-1:0] h_i,
  output logic [SIZE_W-1:0] col_nxt_o,
  output logic [SIZE_W-1:0] row_nxt_o,
  output logic              last_o,
  output logic              edge_nxt_o
);
  logic [SIZE_W-1:0] col_q, row_q, wm1, hm1;
  logic              col_end;

  assign wm1        = w_i - SIZE_W'(1);
  assign hm1        = h_i - SIZE_W'(1);
  assign col_end    = (col_q == wm1);
  assign last_o     = col_end && (row_q == hm1);
  assign col_nxt_o  = col_end ? '0 : col_q + SIZE_W'(1);
  assign row_nxt_o  = col_end ? row_q + SIZE_W'(1) : row_q;
  // Border test of the upcoming position (outline mode keeps only these)
  assign edge_nxt_o = (col_nxt_o == '0) || (col_nxt_o == wm1) ||
                      (row_nxt_o == '0) || (row_nxt_o == hm1);

  always_ff @(posedge clk) begin
    if (!resetn || clr_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (en_i) begin
      col_q <= col_nxt_o;
      row_q <= row_nxt_o;
    end
  end
endmodule

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: one request -> row-major stream of pixel writes.
// Optional screen clipping with `define RECT_DRAW_CLIP_EN.
module rect_draw_engine
  import draw_pkg::*;
#(
  parameter int X_W      = 9,
  parameter int Y_W      = 9,
  parameter int COLOUR_W = 6,
  parameter int SIZE_W   = 9,
  parameter int SCREEN_W = draw_pkg::SCREEN_W,
  parameter int SCREEN_H = draw_pkg::SCREEN_H
) (
  input  logic       clk,
  input  logic       resetn,
  rect_draw_if.slave bus,
  output logic       busy,
  output logic       done
);
`ifdef RECT_DRAW_CLIP_EN
  localparam int XC_W = X_W + 1;
  localparam int YC_W = Y_W + 1;
`else
  localparam int XC_W = X_W;
  localparam int YC_W = Y_W;
`endif

  state_e              state_q;
  logic [X_W-1:0]      x0_q;
  logic [Y_W-1:0]      y0_q;
  logic [SIZE_W-1:0]   w_q, h_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                mode_q;
  logic                pix_valid_q, done_q;
  logic [X_W-1:0]      pix_x_q;
  logic [Y_W-1:0]      pix_y_q;
  logic [COLOUR_W-1:0] pix_colour_q;

  logic [SIZE_W-1:0]   col_nxt, row_nxt;
  logic                last, edge_nxt, advance, step, edge_ok, on_screen, emit;
  logic [XC_W-1:0]     cand_x_d;
  logic [YC_W-1:0]     cand_y_d;

  rect_scan_counter #(.SIZE_W(SIZE_W)) u_scan (
    .clk       (clk),
    .resetn    (resetn),
    .clr_i     (state_q == IDLE),
    .en_i      (step),
    .w_i       (w_q),
    .h_i       (h_q),
    .col_nxt_o (col_nxt),
    .row_nxt_o (row_nxt),
    .last_o    (last),
    .edge_nxt_o(edge_nxt)
  );

  // In IDLE the candidate is the request origin, i.e. position (0,0)
  always_comb begin
    cand_x_d = XC_W'(x0_q) + XC_W'(col_nxt);
    cand_y_d = YC_W'(y0_q) + YC_W'(row_nxt);
    edge_ok  = (mode_q == MODE_FILL) || edge_nxt;
    if (state_q == IDLE) begin
      cand_x_d = XC_W'(bus.req_x);
      cand_y_d = YC_W'(bus.req_y);
      edge_ok  = 1'b1;
    end
  end

`ifdef RECT_DRAW_CLIP_EN
  assign on_screen = (cand_x_d < XC_W'(SCREEN_W)) && (cand_y_d < YC_W'(SCREEN_H));
`else
  logic unused_screen;
  assign unused_screen = SCREEN_W[0] ^ SCREEN_H[0];
  assign on_screen     = 1'b1;
`endif

  assign emit    = edge_ok && on_screen;
  // A suppressed position shows pix_valid=0 and moves on regardless of ready
  assign advance = !pix_valid_q || bus.pix_ready;
  assign step    = (state_q == SCAN) && advance && !last;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      colour_q     <= '0;
      mode_q       <= MODE_FILL;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_colour_q <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.req_valid) begin
          x0_q     <= bus.req_x;
          y0_q     <= bus.req_y;
          w_q      <= bus.req_w;
          h_q      <= bus.req_h;
          colour_q <= bus.req_colour;
          mode_q   <= bus.req_mode;
          if (bus.req_w == '0 || bus.req_h == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q      <= SCAN;
            pix_valid_q  <= emit;
            pix_x_q      <= X_W'(cand_x_d);
            pix_y_q      <= Y_W'(cand_y_d);
            pix_colour_q <= bus.req_colour;
          end
        end
        SCAN: if (advance) begin
          if (last) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            pix_valid_q <= 1'b0;
          end else begin
            pix_valid_q  <= emit;
            pix_x_q      <= X_W'(cand_x_d);
            pix_y_q      <= Y_W'(cand_y_d);
            pix_colour_q <= colour_q;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_x      = pix_x_q;
  assign bus.pix_y      = pix_y_q;
  assign bus.pix_colour = pix_colour_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
endmodule

// File: tb/tb_rect_draw_engine.sv
// Directed bench for rect_draw_engine: fill, outline, backpressure, zero size,
// screen edge (clip or wrap build) and reset mid-scan.
module tb_rect_draw_engine;
  logic clk;
  logic resetn;
  logic busy, done;

  rect_draw_if #(.X_W(9), .Y_W(9), .COLOUR_W(6), .SIZE_W(9)) bus();

  rect_draw_engine #(.X_W(9), .Y_W(9), .COLOUR_W(6), .SIZE_W(9)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int px[$], py[$], pc[$];
  int ex[$], ey[$];
  int done_cyc, ndone, hold_err, nvalid;
  bit rr[64];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int x, input int y, input int w, input int h,
                      input int c, input bit m);
    @(negedge clk);
    bus.req_x      = 9'(x);
    bus.req_y      = 9'(y);
    bus.req_w      = 9'(w);
    bus.req_h      = 9'(h);
    bus.req_colour = 6'(c);
    bus.req_mode   = m;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Cycle k of the run is cycle T+k after the accepting edge T
  task automatic collect(input int n, input bit bp);
    bit held;
    int hx, hy;
    px.delete(); py.delete(); pc.delete();
    done_cyc = -1; ndone = 0; hold_err = 0; nvalid = 0; held = 0; hx = 0; hy = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      bus.pix_ready = bp ? k[0] : 1'b1;
      rr[k] = bus.req_ready;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (bus.pix_valid) nvalid++;
      if (held && (!bus.pix_valid || int'(bus.pix_x) != hx || int'(bus.pix_y) != hy))
        hold_err++;
      if (bus.pix_valid && bus.pix_ready) begin
        px.push_back(int'(bus.pix_x));
        py.push_back(int'(bus.pix_y));
        pc.push_back(int'(bus.pix_colour));
      end
      held = bus.pix_valid && !bus.pix_ready;
      hx = int'(bus.pix_x);
      hy = int'(bus.pix_y);
    end
    bus.pix_ready = 1'b1;
  endtask

  task automatic chk_pixels(input string tag);
    chk({tag, "_count"}, px.size(), ex.size());
    for (int i = 0; i < ex.size(); i++)
      chk($sformatf("%s_pix%0d", tag, i),
          (i < px.size()) ? px[i] * 1000 + py[i] : -1, ex[i] * 1000 + ey[i]);
  endtask

  initial begin
    resetn = 1'b0;
    bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0; bus.req_w = '0;
    bus.req_h = '0; bus.req_colour = '0; bus.req_mode = 1'b0; bus.pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", int'(bus.req_ready), 1);
    chk("rst_pix_valid", int'(bus.pix_valid), 0);
    chk("rst_pix_xy", int'(bus.pix_x) + int'(bus.pix_y) + int'(bus.pix_colour), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    resetn = 1'b1;

    // Fill 4x4 at (10,20)
    send(10, 20, 4, 4, 'h2A, 1'b0);
    collect(18, 1'b0);
    ex.delete(); ey.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin ex.push_back(10 + c); ey.push_back(20 + r); end
    chk_pixels("fill");
    chk("fill_nvalid", nvalid, 16);
    chk("fill_colour", (pc.size() > 0) ? pc[0] : -1, 'h2A);
    chk("fill_done_cyc", done_cyc, 17);
    chk("fill_ndone", ndone, 1);
    chk("fill_rdy_busy", int'(rr[17]), 0);
    chk("fill_rdy_back", int'(rr[18]), 1);

    // Outline 5x3 at (0,0)
    send(0, 0, 5, 3, 'h15, 1'b1);
    collect(17, 1'b0);
    ex = '{0, 1, 2, 3, 4, 0, 4, 0, 1, 2, 3, 4};
    ey = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 2};
    chk_pixels("outline");
    chk("outline_nvalid", nvalid, 12);
    chk("outline_done_cyc", done_cyc, 16);
    chk("outline_rdy_back", int'(rr[17]), 1);

    // Fill 2x2 with ready low on even cycles
    send(7, 9, 2, 2, 'h3F, 1'b0);
    collect(10, 1'b1);
    ex = '{7, 8, 7, 8};
    ey = '{9, 9, 10, 10};
    chk_pixels("bp");
    chk("bp_hold_err", hold_err, 0);
    chk("bp_done_cyc", done_cyc, 8);
    chk("bp_ndone", ndone, 1);

    // Zero width
    send(3, 3, 0, 5, 1, 1'b0);
    collect(3, 1'b0);
    chk("zero_nvalid", nvalid, 0);
    chk("zero_done_cyc", done_cyc, 1);
    chk("zero_rdy_busy", int'(rr[1]), 0);
    chk("zero_rdy_back", int'(rr[2]), 1);

    // Screen right edge
    send(318, 0, 4, 1, 2, 1'b0);
    collect(6, 1'b0);
`ifdef RECT_DRAW_CLIP_EN
    ex = '{318, 319};
    ey = '{0, 0};
`else
    ex = '{318, 319, 320, 321};
    ey = '{0, 0, 0, 0};
`endif
    chk_pixels("edge");
    chk("edge_done_cyc", done_cyc, 5);

    // Reset after three pixels of a 4x4 fill
    send(0, 0, 4, 4, 5, 1'b0);
    collect(3, 1'b0);
    chk("rstmid_pix_before", px.size(), 3);
    @(negedge clk);
    chk("rstmid_busy_before", int'(busy), 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("rstmid_pix_valid", int'(bus.pix_valid), 0);
    chk("rstmid_done", int'(done), 0);
    chk("rstmid_req_ready", int'(bus.req_ready), 1);
    resetn = 1'b1;
    collect(4, 1'b0);
    chk("rstmid_nvalid_after", nvalid, 0);
    chk("rstmid_ndone_after", ndone, 0);
    chk("rstmid_rdy_after", int'(rr[4]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
